// File: rtl/piano_pkg.sv
// Shared types and constants for the polyphonic piano voice block.
//   LEVEL_W     : width of an envelope level / volume (0..15)
//   OCT_W       : width of the octave right-shift
//   MIN_PERIOD  : smallest legal square-wave period in clocks
//   env_state_e : per-channel envelope state encoding
package piano_pkg;

  localparam int unsigned LEVEL_W    = 4;
  localparam int unsigned OCT_W      = 3;
  localparam int unsigned MIN_PERIOD = 2;

  typedef enum logic [1:0] {
    ENV_IDLE    = 2'd0,
    ENV_ATTACK  = 2'd1,
    ENV_SUSTAIN = 2'd2,
    ENV_RELEASE = 2'd3
  } env_state_e;

  // One envelope step from cur toward tgt (holds when equal).
  function automatic logic [LEVEL_W-1:0] step_toward(input logic [LEVEL_W-1:0] cur,
                                                     input logic [LEVEL_W-1:0] tgt);
    if (cur < tgt)      return cur + LEVEL_W'(1);
    else if (cur > tgt) return cur - LEVEL_W'(1);
    else                return cur;
  endfunction

endpackage

// File: rtl/piano_voice_channel.sv
// One square-wave voice: period latch, phase counter, envelope FSM, amplitude.
//   clk, reset  : clock, async active-high reset
//   env_tick    : one-cycle envelope step strobe
//   key_press   : key held level for this channel
//   volume      : sustain target level
//   octave      : right-shift applied to BASE_PERIOD
//   active      : registered, state != IDLE
//   amp_c       : combinational amplitude (square ? level : 0)
module piano_voice_channel
  import piano_pkg::*;
#(
  parameter int unsigned          PERIOD_W    = 32,
  parameter logic [PERIOD_W-1:0]  BASE_PERIOD = PERIOD_W'(3057805)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               env_tick,
  input  logic               key_press,
  input  logic [LEVEL_W-1:0] volume,
  input  logic [OCT_W-1:0]   octave,
  output logic               active,
  output logic [LEVEL_W-1:0] amp_c
);

  env_state_e          state_q, state_d;
  logic [LEVEL_W-1:0]  level_q, level_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] shifted;
  logic [PERIOD_W-1:0] p_req;
  logic                wrap;
  logic                square;

  // Requested period, clamped so the square always has a high and a low half.
  assign shifted = BASE_PERIOD >> octave;
  assign p_req   = (shifted < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD) : shifted;
  assign wrap    = (cnt_q == period_q - PERIOD_W'(1));
  assign square  = (cnt_q < (period_q >> 1));

  // Next-state, level, phase and period latch; period only reloads on wrap or in IDLE.
  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    cnt_d    = wrap ? '0 : cnt_q + PERIOD_W'(1);
    period_d = wrap ? p_req : period_q;
    case (state_q)
      ENV_IDLE: begin
        cnt_d    = '0;
        period_d = p_req;
        if (key_press) state_d = ENV_ATTACK;
      end
      ENV_ATTACK: begin
        if (env_tick && (level_q < volume)) level_d = level_q + LEVEL_W'(1);
        if (!key_press)            state_d = ENV_RELEASE;
        else if (level_q >= volume) state_d = ENV_SUSTAIN;
      end
      ENV_SUSTAIN: begin
        if (env_tick)   level_d = step_toward(level_q, volume);
        if (!key_press) state_d = ENV_RELEASE;
      end
      ENV_RELEASE: begin
        if (env_tick && (level_q != '0)) level_d = level_q - LEVEL_W'(1);
        // Retrigger keeps the running phase.
        if (key_press)             state_d = ENV_ATTACK;
        else if (level_q == '0)    state_d = ENV_IDLE;
      end
      default: state_d = ENV_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ENV_IDLE;
      level_q  <= '0;
      cnt_q    <= '0;
      period_q <= PERIOD_W'(MIN_PERIOD);
      active   <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      active   <= (state_d != ENV_IDLE);
    end
  end

  assign amp_c = ((state_q != ENV_IDLE) && square) ? level_q : '0;

endmodule

// File: rtl/piano_poly_voice.sv
// NUM_CH-key polyphonic square-wave generator with envelopes, mixed to one PWM bit.
//   clk, reset   : clock, async active-high reset
//   volume       : sustain level shared by all voices
//   octave       : right-shift applied to every base period
//   key_press    : per-channel key held
//   voice_active : per-channel state != IDLE
//   mix_level    : registered sum of voice amplitudes
//   output_pwm   : registered PWM of mix_level over a NUM_CH*15 frame
module piano_poly_voice
  import piano_pkg::*;
#(
  parameter int unsigned                 NUM_CH        = 4,
  parameter int unsigned                 PERIOD_W      = 32,
  parameter logic [NUM_CH*PERIOD_W-1:0]  BASE_PERIODS  = {NUM_CH{PERIOD_W'(3057805)}},
  parameter int unsigned                 ENV_STEP_CLKS = 100000
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [LEVEL_W-1:0]                   volume,
  input  logic [OCT_W-1:0]                     octave,
  input  logic [NUM_CH-1:0]                    key_press,
  output logic [NUM_CH-1:0]                    voice_active,
  output logic [LEVEL_W+$clog2(NUM_CH+1)-1:0]  mix_level,
  output logic                                 output_pwm
);

  localparam int unsigned MIX_W = LEVEL_W + $clog2(NUM_CH + 1);
  localparam int unsigned FS    = NUM_CH * 15;
  localparam int unsigned PRE_W = $clog2(ENV_STEP_CLKS + 1);

  logic [PRE_W-1:0]   presc_q;
  logic               env_tick_c;
  logic [LEVEL_W-1:0] amp_c [NUM_CH];
  logic [MIX_W-1:0]   mix_sum_c;
  logic [MIX_W-1:0]   pwm_cnt_q;

  // Envelope step prescaler.
  assign env_tick_c = (presc_q == PRE_W'(ENV_STEP_CLKS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) presc_q <= '0;
    else       presc_q <= env_tick_c ? '0 : presc_q + PRE_W'(1);
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    piano_voice_channel #(
      .PERIOD_W    (PERIOD_W),
      .BASE_PERIOD (BASE_PERIODS[g*PERIOD_W +: PERIOD_W])
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .env_tick  (env_tick_c),
      .key_press (key_press[g]),
      .volume    (volume),
      .octave    (octave),
      .active    (voice_active[g]),
      .amp_c     (amp_c[g])
    );
  end

  // Mixer: width covers NUM_CH*15 so the sum cannot overflow.
  always_comb begin
    mix_sum_c = '0;
    for (int i = 0; i < NUM_CH; i++) mix_sum_c = mix_sum_c + MIX_W'(amp_c[i]);
  end

  // Free-running PWM frame; a mix change never restarts the frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mix_level  <= '0;
      pwm_cnt_q  <= '0;
      output_pwm <= 1'b0;
    end else begin
      mix_level  <= mix_sum_c;
      pwm_cnt_q  <= (pwm_cnt_q == MIX_W'(FS - 1)) ? '0 : pwm_cnt_q + MIX_W'(1);
      output_pwm <= (pwm_cnt_q < mix_level);
    end
  end

endmodule

// File: tb/tb_piano_poly_voice.sv
// Randomized + directed bench for piano_poly_voice against a behavioural model.
module tb_piano_poly_voice;

  localparam int NUM_CH = 2;
  localparam int ENV    = 4;
  localparam int FS     = NUM_CH * 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  volume = '0;
  logic [2:0]  octave = '0;
  logic [1:0]  key_press = '0;
  logic [1:0]  voice_active;
  logic [5:0]  mix_level;
  logic        output_pwm;

  piano_poly_voice #(
    .NUM_CH        (NUM_CH),
    .PERIOD_W      (32),
    .BASE_PERIODS  ({32'd24, 32'd16}),
    .ENV_STEP_CLKS (ENV)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .volume       (volume),
    .octave       (octave),
    .key_press    (key_press),
    .voice_active (voice_active),
    .mix_level    (mix_level),
    .output_pwm   (output_pwm)
  );

  always #5 clk = ~clk;

  // Model: state 0 idle, 1 attack, 2 sustain, 3 release.
  int base [NUM_CH] = '{16, 24};
  int m_st [NUM_CH];
  int m_lvl[NUM_CH];
  int m_cnt[NUM_CH];
  int m_per[NUM_CH];
  int m_presc, m_mix, m_pwm, m_pcnt;

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_st[i] = 0; m_lvl[i] = 0; m_cnt[i] = 0; m_per[i] = 2;
    end
    m_presc = 0; m_mix = 0; m_pwm = 0; m_pcnt = 0;
  endfunction

  function automatic int model_amp(input int i);
    if (m_st[i] != 0 && m_cnt[i] < m_per[i] / 2) return m_lvl[i];
    return 0;
  endfunction

  // One clock edge worth of behaviour, everything derived from pre-edge values.
  function automatic void model_step();
    bit tick;
    int sum, pr, vol;
    bit key;
    if (reset) begin
      model_reset();
      return;
    end
    tick = (m_presc == ENV - 1);
    sum = 0;
    for (int i = 0; i < NUM_CH; i++) sum += model_amp(i);
    m_pwm   = (m_pcnt < m_mix) ? 1 : 0;
    m_mix   = sum;
    m_pcnt  = (m_pcnt + 1) % FS;
    m_presc = (m_presc + 1) % ENV;
    vol = int'(volume);
    for (int i = 0; i < NUM_CH; i++) begin
      key = key_press[i];
      pr = base[i] >> octave;
      if (pr < 2) pr = 2;
      if (m_st[i] == 0) begin
        m_cnt[i] = 0;
        m_per[i] = pr;
        if (key) m_st[i] = 1;
      end else begin
        if (m_cnt[i] == m_per[i] - 1) begin
          m_cnt[i] = 0;
          m_per[i] = pr;
        end else begin
          m_cnt[i]++;
        end
        case (m_st[i])
          1: begin
            int old = m_lvl[i];
            if (tick && old < vol) m_lvl[i] = old + 1;
            if (!key) m_st[i] = 3;
            else if (old >= vol) m_st[i] = 2;
          end
          2: begin
            if (tick) m_lvl[i] += (m_lvl[i] < vol) ? 1 : (m_lvl[i] > vol) ? -1 : 0;
            if (!key) m_st[i] = 3;
          end
          default: begin
            int old = m_lvl[i];
            if (tick && old > 0) m_lvl[i] = old - 1;
            if (key) m_st[i] = 1;
            else if (old == 0) m_st[i] = 0;
          end
        endcase
      end
    end
  endfunction

  task automatic cyc();
    int ea;
    @(posedge clk);
    model_step();
    #1;
    cyc_n++;
    ea = 0;
    for (int i = 0; i < NUM_CH; i++) if (m_st[i] != 0) ea |= (1 << i);
    check_val("voice_active", int'(voice_active), ea);
    check_val("mix_level", int'(mix_level), m_mix);
    check_val("output_pwm", int'(output_pwm), m_pwm);
  endtask

  // Bounded search for a 0 -> nonzero transition of mix_level.
  task automatic wait_rise(output int t, output bit ok);
    int pm;
    ok = 0;
    t = 0;
    for (int k = 0; k < 40; k++) begin
      pm = int'(mix_level);
      cyc();
      if (pm == 0 && mix_level != 0) begin
        ok = 1;
        t = cyc_n;
        break;
      end
    end
    check_val("mix_rise_seen", int'(ok), 1);
  endtask

  initial begin
    int mx, hi, r0, r1, r2, el;
    bit ok, found;

    model_reset();
    #2;
    check_val("reset_voice_active", int'(voice_active), 0);
    check_val("reset_mix_level", int'(mix_level), 0);
    check_val("reset_output_pwm", int'(output_pwm), 0);
    repeat (2) cyc();
    reset = 1'b0;

    // Reset mid-ATTACK clears outputs immediately.
    volume = 4'd15; key_press = 2'b01;
    repeat (6) cyc();
    reset = 1'b1;
    #1;
    check_val("async_reset_active", int'(voice_active), 0);
    check_val("async_reset_mix", int'(mix_level), 0);
    check_val("async_reset_pwm", int'(output_pwm), 0);
    key_press = 2'b00;
    cyc();
    reset = 1'b0;
    repeat (10) cyc();
    check_val("idle_after_reset", int'(voice_active), 0);

    // Single voice, volume 3: square of 16 clocks, 8 high at level 3.
    volume = 4'd3; octave = 3'd0; key_press = 2'b01;
    repeat (20) cyc();
    mx = 0; hi = 0;
    repeat (32) begin
      cyc();
      if (mix_level > mx) mx = int'(mix_level);
      if (mix_level == 3) hi++;
    end
    check_val("sustain_peak", mx, 3);
    check_val("sustain_high_clks", hi, 16);

    // Octave change mid-period: current cycle intact, then halved.
    wait_rise(r0, ok);
    repeat (5) cyc();
    octave = 3'd1;
    wait_rise(r1, ok);
    wait_rise(r2, ok);
    check_val("octave_cycle_intact", r1 - r0, 16);
    check_val("octave_new_period", r2 - r1, 8);

    // Release from level 3: three ticks down then IDLE.
    octave = 3'd0; key_press = 2'b00;
    found = 0; el = 0;
    for (int k = 1; k <= 30; k++) begin
      cyc();
      if (!voice_active[0]) begin found = 1; el = k; break; end
    end
    check_val("release_to_idle", int'(found), 1);
    check_val("release_len_ok", int'(el >= 10 && el <= 13), 1);

    // Retrigger during release keeps phase.
    key_press = 2'b01;
    repeat (20) cyc();
    key_press = 2'b00;
    repeat (6) cyc();
    key_press = 2'b01;
    repeat (20) cyc();

    // Sustain follows volume down.
    volume = 4'd5;
    repeat (30) cyc();
    volume = 4'd2;
    repeat (20) cyc();
    key_press = 2'b00;
    repeat (30) cyc();

    // Volume 0: active but silent.
    volume = 4'd0; key_press = 2'b01;
    repeat (2) cyc();
    for (int k = 0; k < 20; k++) begin
      cyc();
      check_val("silent_active", int'(voice_active[0]), 1);
      check_val("silent_mix", int'(mix_level), 0);
      check_val("silent_pwm", int'(output_pwm), 0);
    end
    key_press = 2'b00;
    repeat (5) cyc();

    // Both voices at full volume reach FS.
    volume = 4'd15; key_press = 2'b11;
    mx = 0;
    repeat (150) begin
      cyc();
      if (mix_level > mx) mx = int'(mix_level);
    end
    check_val("full_mix_peak", mx, FS);
    key_press = 2'b00;
    repeat (80) cyc();

    // Randomized traffic.
    for (int k = 0; k < 2500; k++) begin
      for (int i = 0; i < NUM_CH; i++)
        if ($urandom_range(0, 19) == 0) key_press[i] = ~key_press[i];
      if ($urandom_range(0, 49) == 0) volume = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 59) == 0) octave = 3'($urandom_range(0, 7));
      reset = ($urandom_range(0, 699) == 0);
      cyc();
      reset = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
